// File: rtl/font_rom_arbiter_if.sv
// Request/ROM/return bus for the shared font-ROM arbiter.
// slave = arbiter side, master = requesters plus the ROM instance.
interface font_rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 11,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      addr_rom;
  logic               rom_en;
  logic [DW-1:0]      gline_rom;
  logic [DW-1:0]      gline_o;
  logic [NREQ-1:0]    valid_o;
  logic               busy;

  modport slave (
    input  req, addr_i, gline_rom,
    output gnt, addr_rom, rom_en, gline_o, valid_o, busy
  );

  modport master (
    output req, addr_i, gline_rom,
    input  gnt, addr_rom, rom_en, gline_o, valid_o, busy
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous font ROM between NREQ renderers;
// returns each glyph line with a one-hot owner tag after 2+ROM_LAT cycles.
module font_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int ROM_LAT = 1
) (
  input logic               px_clk,
  input logic               reset,
  font_rom_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0][AW-1:0]     addr_vec;
  logic [PW-1:0]               ptr_q, ptr_d, win_idx;
  logic                        any_req;
  logic [NREQ-1:0]             gnt_c;
  logic [AW-1:0]               addr_rom_q, addr_rom_d;
  logic                        rom_en_q;
  logic [ROM_LAT:0][NREQ-1:0]  tag_pipe_q;
  logic [DW-1:0]               gline_q;
  logic [NREQ-1:0]             valid_q;

  assign addr_vec = bus.addr_i;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_c   = '0;
    win_idx = ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_req && bus.req[wrap_add(ptr_q, k)]) begin
        any_req = 1'b1;
        win_idx = wrap_add(ptr_q, k);
      end
    end
    if (any_req) gnt_c[win_idx] = 1'b1;
    ptr_d      = any_req ? win_idx : ptr_q;
    addr_rom_d = any_req ? addr_vec[win_idx] : addr_rom_q;
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= PW'(NREQ - 1);
      addr_rom_q <= '0;
      rom_en_q   <= 1'b0;
      tag_pipe_q <= '0;
      gline_q    <= '0;
      valid_q    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      addr_rom_q    <= addr_rom_d;
      rom_en_q      <= any_req;
      tag_pipe_q[0] <= gnt_c;
      for (int k = 1; k <= ROM_LAT; k++) tag_pipe_q[k] <= tag_pipe_q[k-1];
      // Last tag stage lines up with gline_rom; bubbles keep the old line.
      valid_q <= tag_pipe_q[ROM_LAT];
      if (|tag_pipe_q[ROM_LAT]) gline_q <= bus.gline_rom;
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.addr_rom = addr_rom_q;
  assign bus.rom_en   = rom_en_q;
  assign bus.gline_o  = gline_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy     = rom_en_q | (|tag_pipe_q);
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter: ROM_LAT=1 main instance, ROM_LAT=3 latency instance.
module tb_font_rom_arbiter;
  logic px_clk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 px_clk = ~px_clk;

  font_rom_arbiter_if #(.NREQ(4), .AW(11), .DW(8)) bif  ();
  font_rom_arbiter_if #(.NREQ(4), .AW(11), .DW(8)) bif3 ();

  font_rom_arbiter #(.NREQ(4), .AW(11), .DW(8), .ROM_LAT(1)) dut1 (
    .px_clk(px_clk), .reset(reset), .bus(bif));
  font_rom_arbiter #(.NREQ(4), .AW(11), .DW(8), .ROM_LAT(3)) dut3 (
    .px_clk(px_clk), .reset(reset), .bus(bif3));

  // ROM contents: 0x041 -> 0x3C
  function automatic logic [7:0] romf(input logic [10:0] a);
    return a[7:0] ^ 8'h7D ^ {5'b0, a[10:8]};
  endfunction

  function automatic logic [10:0] rr_addr(input int i, input int r);
    return 11'(128 + 16 * r + i);
  endfunction

  logic [7:0] rd1;
  logic [7:0] rd3 [3];
  always_ff @(posedge px_clk) rd1 <= romf(bif.addr_rom);
  always_ff @(posedge px_clk) begin
    rd3[0] <= romf(bif3.addr_rom);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign bif.gline_rom  = rd1;
  assign bif3.gline_rom = rd3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge px_clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [10:0] a);
    bif.addr_i[i*11 +: 11] = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.req = '0;  bif.addr_i = '0;
    bif3.req = '0; bif3.addr_i = '0;
    step(); step();

    // reset state
    chk("rst_addr_rom", 32'(bif.addr_rom), 32'h0);
    chk("rst_rom_en",   32'(bif.rom_en),   32'h0);
    chk("rst_gline",    32'(bif.gline_o),  32'h0);
    chk("rst_valid",    32'(bif.valid_o),  32'h0);
    chk("rst_busy",     32'(bif.busy),     32'h0);
    bif.req = 4'b1111;
    #1;
    chk("rst_ptr_gnt", 32'(bif.gnt), 32'h1);
    bif.req = '0;
    reset = 1'b0;
    step();

    // single request
    set_addr(0, 11'h041);
    bif.req = 4'b0001;
    #1;
    chk("single_gnt", 32'(bif.gnt), 32'h1);
    step();
    bif.req = '0;
    chk("single_addr_rom", 32'(bif.addr_rom), 32'h041);
    chk("single_rom_en",   32'(bif.rom_en),   32'h1);
    chk("single_valid_t1", 32'(bif.valid_o),  32'h0);
    step();
    chk("single_valid_t2", 32'(bif.valid_o),  32'h0);
    chk("single_rom_en_t2", 32'(bif.rom_en),  32'h0);
    chk("single_addr_hold", 32'(bif.addr_rom), 32'h041);
    step();
    chk("single_valid", 32'(bif.valid_o), 32'h1);
    chk("single_gline", 32'(bif.gline_o), 32'h3C);
    step();
    chk("bubble_valid", 32'(bif.valid_o), 32'h0);
    chk("bubble_gline", 32'(bif.gline_o), 32'h3C);
    chk("idle_busy",    32'(bif.busy),    32'h0);

    // round robin from reset pointer
    do_reset();
    for (int n = 0; n < 11; n++) begin
      if (n < 8) begin
        bif.req = 4'b1111;
        for (int i = 0; i < 4; i++)
          set_addr(i, rr_addr(i, ((n % 4) <= i) ? n / 4 : n / 4 + 1));
      end else bif.req = '0;
      #1;
      if (n < 8) chk("rr_gnt", 32'(bif.gnt), 32'(1 << (n % 4)));
      if (n >= 3) begin
        chk("rr_valid", 32'(bif.valid_o), 32'(1 << ((n - 3) % 4)));
        chk("rr_gline", 32'(bif.gline_o), 32'(romf(rr_addr((n - 3) % 4, (n - 3) / 4))));
      end else chk("rr_valid_early", 32'(bif.valid_o), 32'h0);
      step();
    end

    // pointer continuity: last winner 3, then 2, then 0 before 2
    bif.req = 4'b0100;
    #1;
    chk("ptr_gnt2", 32'(bif.gnt), 32'h4);
    step();
    bif.req = 4'b0101;
    #1;
    chk("ptr_gnt0", 32'(bif.gnt), 32'h1);
    step();
    #1;
    chk("ptr_gnt2b", 32'(bif.gnt), 32'h4);
    step();
    bif.req = '0;
    step(); step(); step(); step();

    // lone streaming requester 2, addresses 10..14
    for (int n = 0; n < 9; n++) begin
      if (n < 5) begin
        bif.req = 4'b0100;
        set_addr(2, 11'(10 + n));
      end else bif.req = '0;
      #1;
      if (n < 5) chk("stream_gnt", 32'(bif.gnt), 32'h4);
      if (n >= 1 && n <= 6) chk("stream_busy", 32'(bif.busy), 32'h1);
      if (n >= 3 && n <= 7) begin
        chk("stream_valid", 32'(bif.valid_o), 32'h4);
        chk("stream_gline", 32'(bif.gline_o), 32'(romf(11'(10 + n - 3))));
      end
      if (n == 8) begin
        chk("stream_end_valid", 32'(bif.valid_o), 32'h0);
        chk("stream_end_busy",  32'(bif.busy),    32'h0);
      end
      step();
    end

    // ROM_LAT=3 instance
    bif3.addr_i[10:0] = 11'h041;
    bif3.req = 4'b0001;
    #1;
    chk("lat3_gnt", 32'(bif3.gnt), 32'h1);
    step();
    bif3.req = '0;
    chk("lat3_rom_en", 32'(bif3.rom_en), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      chk("lat3_no_pulse", 32'(bif3.valid_o), 32'h0);
      chk("lat3_busy", 32'(bif3.busy), 32'h1);
      step();
    end
    chk("lat3_valid", 32'(bif3.valid_o), 32'h1);
    chk("lat3_gline", 32'(bif3.gline_o), 32'h3C);

    // reset mid-flight
    step();
    set_addr(0, 11'h123);
    bif.req = 4'b0001;
    #1;
    chk("mid_gnt0", 32'(bif.gnt), 32'h1);
    step();
    set_addr(1, 11'h234);
    bif.req = 4'b0010;
    #1;
    chk("mid_gnt1", 32'(bif.gnt), 32'h2);
    step();
    bif.req = '0;
    reset = 1'b1;
    #1;
    chk("mid_addr_rom", 32'(bif.addr_rom), 32'h0);
    chk("mid_rom_en",   32'(bif.rom_en),   32'h0);
    chk("mid_gline",    32'(bif.gline_o),  32'h0);
    chk("mid_valid",    32'(bif.valid_o),  32'h0);
    chk("mid_busy",     32'(bif.busy),     32'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("mid_no_pulse", 32'(bif.valid_o), 32'h0);
      step();
    end
    bif.req = 4'b0011;
    #1;
    chk("mid_ptr_gnt", 32'(bif.gnt), 32'h1);
    bif.req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
